// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int MAX_NREQ = 8;

    // Ceiling log2 with a floor of 1 so single-bit indices stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Rotating-priority encoder: first set req bit at or after rr_ptr, wrapping mod NREQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2(NREQ)-1:0]   rr_ptr,
    output logic                     any,
    output logic [clog2(NREQ)-1:0]   winner
);

    localparam int IW = clog2(NREQ);

    always_comb begin
        int idx;
        idx    = 0;
        any    = |req;
        winner = '0;
        // Scan farthest-first so the entry closest to rr_ptr is written last and wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx -= NREQ;
            if (req[idx]) winner = IW'(idx);
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NREQ requesters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [clog2(NREQ)-1:0]   owner,
    output logic                     busy,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DSIZE-1:0]         fifo_din
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    arb_state_t     state;
    logic [IW-1:0]  rr_ptr;
    logic [CW-1:0]  beat_cnt;
    logic           any;
    logic [IW-1:0]  winner;
    logic [IW-1:0]  sel;
    logic           accept;

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] p);
        return (p == IW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (any),
        .winner (winner)
    );

    // Accept is gated by rstn so a beat presented while reset is low never looks granted.
    always_comb begin
        sel        = (state == BURST) ? owner : winner;
        accept     = rstn && !fifo_full && ((state == BURST) ? req[owner] : any);
        fifo_wr_en = accept;
        busy       = (state == BURST);
        gnt        = '0;
        fifo_din   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (accept && sel == IW'(i)) begin
                gnt[i]   = 1'b1;
                fifo_din = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= winner;
                        beat_cnt <= CW'(1);
                        if (MAX_BURST > 1) state <= BURST;
                        else               rr_ptr <= inc_wrap(winner);
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= inc_wrap(owner);
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state  <= IDLE;
                            rr_ptr <= inc_wrap(owner);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a requester data model and a depth-16 FIFO model.
module tb_fifo_write_arbiter;

    localparam int NREQ  = 3;
    localparam int DSIZE = 8;
    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [NREQ-1:0]        req;
    logic [NREQ*DSIZE-1:0]  req_data;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             owner;
    logic                   busy;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DSIZE-1:0]       fifo_din;

    int errors = 0;
    int checks = 0;

    logic [7:0] base [NREQ];
    logic [7:0] dcnt [NREQ];
    logic [7:0] wq [$];
    int         cnt;
    logic       auto_full;

    logic [7:0] t2_exp [16];
    logic [2:0] t3_req [5];
    logic [2:0] t3_gnt [5];
    logic       t3_bsy [5];
    logic       t4_full [8];
    logic [2:0] t4_req [8];
    logic [2:0] t4_gnt [8];
    logic       t4_bsy [8];

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .owner      (owner),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        wq.delete();
        cnt = 0;
        for (int i = 0; i < NREQ; i++) dcnt[i] = 8'h00;
    endtask

    // One cycle: drive at negedge, sample combinational outputs 1ns later, log the write.
    task automatic cyc(input logic [NREQ-1:0] r, input logic f);
        @(negedge clk);
        req = r;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = base[i] + dcnt[i];
        fifo_full = f | (auto_full && cnt >= DEPTH);
        #1;
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            cnt++;
        end
        for (int i = 0; i < NREQ; i++) if (gnt[i]) dcnt[i]++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        req  = '0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 0);
        chk({tag, "_wr"},    32'(fifo_wr_en), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_din"},   32'(fifo_din), 0);
        chk({tag, "_owner"}, 32'(owner), 0);
    endtask

    initial begin
        base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0;
        t2_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
                   8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
        t3_req = '{3'b010, 3'b010, 3'b100, 3'b101, 3'b000};
        t3_gnt = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b000};
        t3_bsy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t4_full = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        t4_req  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
        t4_gnt  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
        t4_bsy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rstn = 1'b0; req = '1; req_data = '0; fifo_full = 1'b0; auto_full = 1'b0;
        clear_model();

        // Reset: outputs forced low even with every requester asking
        @(negedge clk); #1;
        chk_all_zero("rst");
        req = '0;
        @(negedge clk);
        rstn = 1'b1;

        // 1: single requester, one full burst
        clear_model();
        for (int c = 0; c < 4; c++) begin
            cyc(3'b001, 1'b0);
            chk("t1_gnt", 32'(gnt), 32'h1);
            chk("t1_busy", 32'(busy), 32'(c != 0));
        end
        cyc(3'b000, 1'b0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_gnt", 32'(gnt), 0);
        chk("t1_nwr", 32'(wq.size()), 4);
        for (int k = 0; k < 4; k++) chk("t1_data", 32'(wq[k]), 32'(8'hA0 + k));

        // 2: all requesting, rotation 0,1,2,0 with 4-beat bursts
        pulse_reset();
        clear_model();
        for (int c = 0; c < 16; c++) begin
            int ord;
            ord = (c / 4) % 3;
            cyc(3'b111, 1'b0);
            chk("t2_gnt", 32'(gnt), 32'(1 << ord));
            chk("t2_busy", 32'(busy), 32'((c % 4) != 0));
        end
        chk("t2_nwr", 32'(wq.size()), 16);
        for (int k = 0; k < 16; k++) chk("t2_data", 32'(wq[k]), 32'(t2_exp[k]));

        // 3: requester 1 drops after 2 beats; next pick starts at requester 2
        clear_model();
        for (int c = 0; c < 5; c++) begin
            cyc(t3_req[c], 1'b0);
            chk("t3_gnt", 32'(gnt), 32'(t3_gnt[c]));
            chk("t3_busy", 32'(busy), 32'(t3_bsy[c]));
        end
        chk("t3_nwr", 32'(wq.size()), 3);

        // 4: FIFO full stalls the burst after beat 2 for three cycles
        clear_model();
        for (int c = 0; c < 8; c++) begin
            cyc(t4_req[c], t4_full[c]);
            chk("t4_gnt", 32'(gnt), 32'(t4_gnt[c]));
            chk("t4_wr", 32'(fifo_wr_en), 32'(t4_gnt[c] != 0));
            chk("t4_busy", 32'(busy), 32'(t4_bsy[c]));
        end
        chk("t4_nwr", 32'(wq.size()), 4);
        chk("t4_owner", 32'(owner), 0);

        // 5: fill to depth with no reads
        clear_model();
        auto_full = 1'b1;
        for (int c = 0; c < 24; c++) begin
            cyc(3'b111, 1'b0);
            chk("t5_wr_full", 32'(fifo_wr_en & fifo_full), 0);
        end
        chk("t5_nwr", 32'(wq.size()), DEPTH);
        chk("t5_gnt_full", 32'(gnt), 0);
        auto_full = 1'b0;

        // 6: reset during beat 3 of a burst owned by requester 2
        clear_model();
        cyc(3'b111, 1'b0);
        chk("t6_gnt0", 32'(gnt), 32'h4);
        cyc(3'b111, 1'b0);
        chk("t6_gnt1", 32'(gnt), 32'h4);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        req = '0;
        @(negedge clk);
        rstn = 1'b1;
        cyc(3'b111, 1'b0);
        chk("t6_post_gnt", 32'(gnt), 32'h1);
        chk("t6_post_busy", 32'(busy), 0);
        cyc(3'b111, 1'b0);
        chk("t6_post_gnt2", 32'(gnt), 32'h1);
        chk("t6_post_owner", 32'(owner), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
